// File: rtl/tdc_meas_sched.sv
// Measurement scheduler for the ring-interpolated TDC: launches N events, waits for each
// hamming-weight result with a timeout, and accumulates sum/min/max of the readings.
module tdc_meas_sched #(
    parameter int HW_W    = 7,
    parameter int N_W     = 8,
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [N_W-1:0]      n_samples,
    input  logic                src_sel,
    input  logic                bypass,
    output logic                tdc_pg_in,
    output logic                tdc_val_in,
    output logic                tdc_pg_src,
    output logic                tdc_pg_bypass,
    input  logic [HW_W-1:0]     tdc_hw,
    input  logic                tdc_val_out,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [N_W-1:0]      count,
    output logic [HW_W+N_W-1:0] sum,
    output logic [HW_W-1:0]     hw_min,
    output logic [HW_W-1:0]     hw_max
);

    localparam int CNT_MAX = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, SETTLE_S, LAUNCH, WAIT, FIN} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [N_W-1:0]        n_q, n_d;
    logic [N_W-1:0]        count_q, count_d;
    logic [N_W:0]          count_inc;
    logic [HW_W+N_W-1:0]   sum_q, sum_d;
    logic [HW_W-1:0]       min_q, min_d;
    logic [HW_W-1:0]       max_q, max_d;
    logic                  src_q, src_d;
    logic                  byp_q, byp_d;
    logic                  pg_q, pg_d;
    logic                  err_q, err_d;

    assign count_inc = {1'b0, count_q} + (N_W+1)'(1);

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        count_d = count_q;
        sum_d   = sum_q;
        min_d   = min_q;
        max_d   = max_q;
        src_d   = src_q;
        byp_d   = byp_q;
        err_d   = err_q;

        if (abort && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        n_d     = n_samples;
                        src_d   = src_sel;
                        byp_d   = bypass;
                        count_d = '0;
                        sum_d   = '0;
                        err_d   = 1'b0;
                        max_d   = '0;
                        min_d   = '1;
                        state_d = (n_samples == '0) ? FIN : SETTLE_S;
                    end
                end
                SETTLE_S: begin
                    if (cnt_q == CNT_W'(SETTLE - 1)) state_d = LAUNCH;
                end
                LAUNCH: state_d = WAIT;
                WAIT: begin
                    // A result on the final timeout cycle still counts as a valid sample.
                    if (tdc_val_out) begin
                        count_d = count_inc[N_W-1:0];
                        sum_d   = sum_q + (HW_W+N_W)'(tdc_hw);
                        if (tdc_hw < min_q) min_d = tdc_hw;
                        if (tdc_hw > max_q) max_d = tdc_hw;
                        state_d = (count_inc == {1'b0, n_q}) ? FIN : SETTLE_S;
                    end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end
                end
                FIN:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // With no accumulated sample the all-ones seed is meaningless, so report zero.
        if (state_d == FIN && count_d == '0) min_d = '0;

        cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + CNT_W'(1);
        // Toggle on entry so the edge is visible in the same cycle as tdc_val_in.
        pg_d  = (state_d == LAUNCH && state_q != LAUNCH) ? ~pg_q : pg_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            count_q <= '0;
            sum_q   <= '0;
            min_q   <= '0;
            max_q   <= '0;
            src_q   <= 1'b0;
            byp_q   <= 1'b0;
            pg_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            min_q   <= min_d;
            max_q   <= max_d;
            src_q   <= src_d;
            byp_q   <= byp_d;
            pg_q    <= pg_d;
            err_q   <= err_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign done          = (state_q == FIN);
    assign tdc_val_in    = (state_q == LAUNCH);
    assign tdc_pg_in     = pg_q;
    assign tdc_pg_src    = src_q;
    assign tdc_pg_bypass = byp_q;
    assign err           = err_q;
    assign count         = count_q;
    assign sum           = sum_q;
    assign hw_min        = min_q;
    assign hw_max        = max_q;

endmodule

// File: tb/tb_tdc_meas_sched.sv
// Bench for tdc_meas_sched: a per-cycle expected timeline is planned from the run rules,
// then one compare process checks every output against it; literal checkpoints pin the plan.
module tb_tdc_meas_sched;

    localparam int HW_W    = 7;
    localparam int N_W     = 8;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 16;
    localparam int MAXC    = 512;
    localparam int HOR     = 250;

    logic                clk;
    logic                rst;
    logic                start;
    logic                abort;
    logic [N_W-1:0]      n_samples;
    logic                src_sel;
    logic                bypass;
    logic                tdc_pg_in;
    logic                tdc_val_in;
    logic                tdc_pg_src;
    logic                tdc_pg_bypass;
    logic [HW_W-1:0]     tdc_hw;
    logic                tdc_val_out;
    logic                busy;
    logic                done;
    logic                err;
    logic [N_W-1:0]      count;
    logic [HW_W+N_W-1:0] sum;
    logic [HW_W-1:0]     hw_min;
    logic [HW_W-1:0]     hw_max;

    tdc_meas_sched #(.HW_W(HW_W), .N_W(N_W), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .n_samples    (n_samples),
        .src_sel      (src_sel),
        .bypass       (bypass),
        .tdc_pg_in    (tdc_pg_in),
        .tdc_val_in   (tdc_val_in),
        .tdc_pg_src   (tdc_pg_src),
        .tdc_pg_bypass(tdc_pg_bypass),
        .tdc_hw       (tdc_hw),
        .tdc_val_out  (tdc_val_out),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .count        (count),
        .sum          (sum),
        .hw_min       (hw_min),
        .hw_max       (hw_max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus timeline
    int d_start[MAXC], d_abort[MAXC], d_n[MAXC], d_src[MAXC], d_byp[MAXC];
    int d_vout[MAXC], d_hw[MAXC];
    // Expected output timeline
    int e_busy[MAXC], e_done[MAXC], e_vin[MAXC], e_pg[MAXC];
    int e_src[MAXC], e_byp[MAXC], e_err[MAXC];
    int e_cnt[MAXC], e_sum[MAXC], e_min[MAXC], e_max[MAXC];

    int p_dly[8];
    int p_hw[8];
    int pg_lvl = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;
    int n_cmp  = 0;
    int n_err  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic fill_res(input int from, input int cn, input int sm, input int mn,
                            input int mx, input int er);
        for (int c = from; c < MAXC; c++) begin
            e_cnt[c] = cn; e_sum[c] = sm; e_min[c] = mn; e_max[c] = mx; e_err[c] = er;
        end
    endtask

    task automatic fill_pg(input int from, input int v);
        for (int c = from; c < MAXC; c++) e_pg[c] = v;
    endtask

    task automatic fill_cfg(input int from, input int src, input int byp);
        for (int c = from; c < MAXC; c++) begin
            e_src[c] = src; e_byp[c] = byp;
        end
    endtask

    // Lays out one run: start at cycle s, SETTLE idle cycles before each launch, results
    // from p_dly/p_hw (delay 0 = TDC never answers), optional abort at cycle abort_at.
    task automatic plan_run(input int s, input int n, input int src, input int byp,
                            input int abort_at);
        int cn, sm, mn, mx, er, t, L, r, fin, k;
        d_start[s] = 1; d_n[s] = n; d_src[s] = src; d_byp[s] = byp;
        fill_cfg(s + 1, src, byp);
        cn = 0; sm = 0; mx = 0; er = 0;
        mn = (n == 0) ? 0 : (1 << HW_W) - 1;
        fill_res(s + 1, cn, sm, mn, mx, er);
        fin = -1;
        if (n == 0) fin = s + 1;
        t = s + 1;
        k = 0;
        while (fin < 0) begin
            L = t + SETTLE;
            for (int c = t; c <= L; c++) e_busy[c] = 1;
            e_vin[L] = 1;
            pg_lvl ^= 1;
            fill_pg(L, pg_lvl);
            if (p_dly[k] > 0) begin
                r = L + p_dly[k];
                for (int c = L + 1; c <= r; c++) e_busy[c] = 1;
                d_vout[r] = 1; d_hw[r] = p_hw[k];
                cn++;
                sm += p_hw[k];
                if (p_hw[k] < mn) mn = p_hw[k];
                if (p_hw[k] > mx) mx = p_hw[k];
                fill_res(r + 1, cn, sm, mn, mx, er);
                k++;
                if (k == n) fin = r + 1;
                else t = r + 1;
            end else begin
                fin = L + TIMEOUT + 2;
                for (int c = L + 1; c < fin; c++) e_busy[c] = 1;
                er = 1;
                if (cn == 0) mn = 0;
                fill_res(fin, cn, sm, mn, mx, er);
            end
        end
        e_busy[fin] = 1;
        e_done[fin] = 1;
        if (abort_at >= 0) begin
            d_abort[abort_at] = 1;
            for (int c = abort_at + 1; c <= fin; c++) begin
                e_busy[c] = 0; e_done[c] = 0; e_vin[c] = 0; d_vout[c] = 0; d_hw[c] = 0;
            end
            fill_res(abort_at + 1, e_cnt[abort_at], e_sum[abort_at], e_min[abort_at],
                     e_max[abort_at], e_err[abort_at]);
            pg_lvl = e_pg[abort_at];
            fill_pg(abort_at + 1, pg_lvl);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && cyc < MAXC) begin
            chk("busy",       int'(busy),          e_busy[cyc]);
            chk("done",       int'(done),          e_done[cyc]);
            chk("tdc_val_in", int'(tdc_val_in),    e_vin[cyc]);
            chk("tdc_pg_in",  int'(tdc_pg_in),     e_pg[cyc]);
            chk("pg_src",     int'(tdc_pg_src),    e_src[cyc]);
            chk("pg_bypass",  int'(tdc_pg_bypass), e_byp[cyc]);
            chk("err",        int'(err),           e_err[cyc]);
            chk("count",      int'(count),         e_cnt[cyc]);
            chk("sum",        int'(sum),           e_sum[cyc]);
            chk("hw_min",     int'(hw_min),        e_min[cyc]);
            chk("hw_max",     int'(hw_max),        e_max[cyc]);
        end
    end

    task automatic wait_launch(input string nm);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (tdc_val_in) got = 1'b1;
        end
        chk(nm, int'(got), 1);
    endtask

    task automatic respond(input int hwv);
        @(posedge clk); #1;
        tdc_val_out = 1'b1; tdc_hw = HW_W'(hwv);
        @(posedge clk); #1;
        tdc_val_out = 1'b0; tdc_hw = '0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; n_samples = '0;
        src_sel = 1'b0; bypass = 1'b0; tdc_hw = '0; tdc_val_out = 1'b0;

        // Scenario 1: four results 10,20,5,40, plus stray valids in SETTLE and IDLE
        p_dly[0] = 1; p_dly[1] = 1; p_dly[2] = 1; p_dly[3] = 1;
        p_hw[0] = 10; p_hw[1] = 20; p_hw[2] = 5; p_hw[3] = 40;
        plan_run(5, 4, 1, 0, -1);
        d_vout[7] = 1; d_hw[7] = 1;
        d_vout[45] = 1; d_hw[45] = 99;
        // Scenario 2: second launch never answered -> timeout
        p_dly[0] = 3; p_dly[1] = 0; p_hw[0] = 7;
        plan_run(50, 3, 0, 1, -1);
        // Scenario 3: first result on the last timeout cycle
        p_dly[0] = TIMEOUT + 1; p_dly[1] = 2; p_hw[0] = 100; p_hw[1] = 127;
        plan_run(110, 2, 1, 1, -1);
        // Scenario 4: zero samples
        plan_run(160, 0, 0, 0, -1);
        // Scenario 5: stray starts during run, inputs change, abort mid-SETTLE
        for (int i = 0; i < 8; i++) begin p_dly[i] = 1; p_hw[i] = 3; end
        plan_run(180, 5, 1, 1, 188);
        d_start[182] = 1; d_n[182] = 9;
        d_start[186] = 1; d_n[186] = 2;
        // Scenario 6: first launch times out, no sample at all
        p_dly[0] = 0;
        plan_run(220, 1, 0, 1, -1);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",   int'(busy),       0);
        chk("rst_done",   int'(done),       0);
        chk("rst_pg_in",  int'(tdc_pg_in),  0);
        chk("rst_val_in", int'(tdc_val_in), 0);
        chk("rst_count",  int'(count),      0);
        chk("rst_hw_min", int'(hw_min),     0);
        rst = 1'b0;
        @(posedge clk); #1;

        chk_en = 1'b1;
        for (int c = 0; c < HOR; c++) begin
            cyc         = c;
            start       = (d_start[c] != 0);
            abort       = (d_abort[c] != 0);
            n_samples   = N_W'(d_n[c]);
            src_sel     = (d_src[c] != 0);
            bypass      = (d_byp[c] != 0);
            tdc_val_out = (d_vout[c] != 0);
            tdc_hw      = HW_W'(d_hw[c]);
            #3;
            case (c)
                30:  chk("s1_done", int'(done), 1);
                31: begin
                    chk("s1_count", int'(count), 4);
                    chk("s1_sum",   int'(sum), 75);
                    chk("s1_min",   int'(hw_min), 5);
                    chk("s1_max",   int'(hw_max), 40);
                    chk("s1_err",   int'(err), 0);
                    chk("s1_pg",    int'(tdc_pg_in), 0);
                end
                80: begin
                    chk("s2_done_early", int'(done), 0);
                    chk("s2_err_early",  int'(err), 0);
                end
                81: begin
                    chk("s2_done", int'(done), 1);
                    chk("s2_err",  int'(err), 1);
                end
                82: begin
                    chk("s2_busy",  int'(busy), 0);
                    chk("s2_count", int'(count), 1);
                    chk("s2_sum",   int'(sum), 7);
                    chk("s2_max",   int'(hw_max), 7);
                end
                140: chk("s3_done", int'(done), 1);
                141: begin
                    chk("s3_err",   int'(err), 0);
                    chk("s3_count", int'(count), 2);
                    chk("s3_sum",   int'(sum), 227);
                    chk("s3_min",   int'(hw_min), 100);
                    chk("s3_max",   int'(hw_max), 127);
                end
                161: begin
                    chk("s4_done", int'(done), 1);
                    chk("s4_min",  int'(hw_min), 0);
                end
                162: begin
                    chk("s4_busy",  int'(busy), 0);
                    chk("s4_sum",   int'(sum), 0);
                end
                189: begin
                    chk("s5_busy", int'(busy), 0);
                    chk("s5_done", int'(done), 0);
                end
                190: begin
                    chk("s5_count", int'(count), 1);
                    chk("s5_sum",   int'(sum), 3);
                    chk("s5_src",   int'(tdc_pg_src), 1);
                    chk("s5_byp",   int'(tdc_pg_bypass), 1);
                end
                243: begin
                    chk("s6_done",  int'(done), 1);
                    chk("s6_err",   int'(err), 1);
                    chk("s6_min",   int'(hw_min), 0);
                    chk("s6_count", int'(count), 0);
                end
                244: chk("s6_busy", int'(busy), 0);
                default: ;
            endcase
            @(posedge clk); #1;
        end
        chk_en = 1'b0;

        // Asynchronous reset in the WAIT of the third launch
        n_samples = 8'd3; src_sel = 1'b1; bypass = 1'b1; start = 1'b1;
        tdc_val_out = 1'b0; tdc_hw = '0;
        @(posedge clk); #1;
        start = 1'b0; src_sel = 1'b0; bypass = 1'b0;
        wait_launch("ar_launch1");
        respond(50);
        wait_launch("ar_launch2");
        respond(50);
        wait_launch("ar_launch3");
        @(posedge clk); @(posedge clk); #2;
        chk("ar_busy_before",  int'(busy), 1);
        chk("ar_count_before", int'(count), 2);
        chk("ar_pg_before",    int'(tdc_pg_in), 1);
        rst = 1'b1;
        #1;
        chk("ar_busy",   int'(busy), 0);
        chk("ar_done",   int'(done), 0);
        chk("ar_err",    int'(err), 0);
        chk("ar_count",  int'(count), 0);
        chk("ar_sum",    int'(sum), 0);
        chk("ar_min",    int'(hw_min), 0);
        chk("ar_max",    int'(hw_max), 0);
        chk("ar_pg_in",  int'(tdc_pg_in), 0);
        chk("ar_src",    int'(tdc_pg_src), 0);
        chk("ar_byp",    int'(tdc_pg_bypass), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("ar_busy_held", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
